// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader: preamble/sync detection, length-count capture,
// header and per-frame framing checks, parallel frame write-out with address.
module xc20xx_cfg_loader #(
   parameter int FRAME_BITS = 71,
   parameter int NUM_FRAMES = 160,
   parameter int STOP_BITS  = 3,
   parameter int ADDR_W     = 8
) (
   input  logic                  K,
   input  logic                  RST_N,
   input  logic                  DIN,
   input  logic                  DIN_VALID,
   output logic [FRAME_BITS-1:0] FRAME_DATA,
   output logic [ADDR_W-1:0]     FRAME_ADDR,
   output logic                  FRAME_WE,
   output logic [23:0]           LEN_CNT,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   typedef enum logic [3:0] {
      S_PRE, S_SYNC, S_LEN, S_HEND, S_FSTART, S_FDATA, S_FSTOP, S_DONE, S_ERR
   } state_t;

   localparam int CNT_MAX = (FRAME_BITS > 24) ? FRAME_BITS : 24;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  SYNC_MID   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(2);
   localparam logic [CNT_W-1:0]  HEND_LAST  = CNT_W'(3);
   localparam logic [CNT_W-1:0]  LEN_LAST   = CNT_W'(23);
   localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]  STOP_LAST  = CNT_W'(STOP_BITS - 1);
   localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(NUM_FRAMES - 1);

   state_t                  state, state_nx;
   logic [3:0]              pre_cnt, pre_nx;
   logic [CNT_W-1:0]        bit_cnt, cnt_nx;
   logic [ADDR_W-1:0]       frame_cnt;
   logic [FRAME_BITS-1:0]   shreg;
   logic                    accept;
   logic                    shift_len;
   logic                    shift_frame;
   logic                    commit;

   assign accept = DIN_VALID;

   // State register, including the preamble and bit counters that qualify transitions
   always_ff @(posedge K) begin
      if (!RST_N) begin
         state   <= S_PRE;
         pre_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nx;
         pre_cnt <= pre_nx;
         bit_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pre_nx   = pre_cnt;
      cnt_nx   = bit_cnt;
      if (accept) begin
         unique case (state)
            S_PRE: begin
               if (DIN) begin
                  if (pre_cnt != 4'd8) pre_nx = pre_cnt + 4'd1;
               end else if (pre_cnt == 4'd8) begin
                  state_nx = S_SYNC;
                  pre_nx   = '0;
                  cnt_nx   = '0;
               end else begin
                  pre_nx = '0;
               end
            end
            // Remaining sync bits are 0,1,0: only the middle one is a 1
            S_SYNC: begin
               if (DIN != (bit_cnt == SYNC_MID)) begin
                  state_nx = S_PRE;
                  pre_nx   = DIN ? 4'd1 : 4'd0;
               end else if (bit_cnt == SYNC_LAST) begin
                  state_nx = S_LEN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end
            S_LEN: begin
               if (bit_cnt == LEN_LAST) begin
                  state_nx = S_HEND;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end
            S_HEND: begin
               if (!DIN) begin
                  state_nx = S_ERR;
               end else if (bit_cnt == HEND_LAST) begin
                  state_nx = S_FSTART;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end
            S_FSTART: begin
               if (DIN) begin
                  state_nx = S_ERR;
               end else begin
                  state_nx = S_FDATA;
                  cnt_nx   = '0;
               end
            end
            S_FDATA: begin
               if (bit_cnt == DATA_LAST) begin
                  state_nx = S_FSTOP;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end
            S_FSTOP: begin
               if (!DIN) begin
                  state_nx = S_ERR;
               end else if (bit_cnt == STOP_LAST) begin
                  state_nx = (frame_cnt == FRAME_LAST) ? S_DONE : S_FSTART;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = bit_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      BUSY        = (state != S_PRE) && (state != S_DONE) && (state != S_ERR);
      DONE        = (state == S_DONE);
      ERR         = (state == S_ERR);
      shift_len   = accept && (state == S_LEN);
      shift_frame = accept && (state == S_FDATA);
      commit      = accept && (state == S_FSTOP) && DIN && (bit_cnt == STOP_LAST);
   end

   // Output registers: frame write-out and captured length count
   always_ff @(posedge K) begin
      if (!RST_N) begin
         FRAME_WE   <= 1'b0;
         FRAME_DATA <= '0;
         FRAME_ADDR <= '0;
         LEN_CNT    <= '0;
         frame_cnt  <= '0;
      end else begin
         FRAME_WE <= commit;
         if (shift_len) LEN_CNT <= {LEN_CNT[22:0], DIN};
         if (commit) begin
            FRAME_DATA <= shreg;
            FRAME_ADDR <= frame_cnt;
            frame_cnt  <= frame_cnt + 1'b1;
         end
      end
   end

   // Frame shift register: contents only matter once a full frame has been shifted in
   always_ff @(posedge K) begin
      if (shift_frame) shreg <= {shreg[FRAME_BITS-2:0], DIN};
   end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Directed bench for xc20xx_cfg_loader with a frame-write scoreboard.
module tb_xc20xx_cfg_loader;

   localparam int FRAME_BITS = 4;
   localparam int NUM_FRAMES = 2;
   localparam int STOP_BITS  = 3;
   localparam int ADDR_W     = 8;

   logic                  K = 1'b0;
   logic                  RST_N = 1'b0;
   logic                  DIN = 1'b0;
   logic                  DIN_VALID = 1'b0;
   logic [FRAME_BITS-1:0] FRAME_DATA;
   logic [ADDR_W-1:0]     FRAME_ADDR;
   logic                  FRAME_WE;
   logic [23:0]           LEN_CNT;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERR;

   xc20xx_cfg_loader #(
      .FRAME_BITS(FRAME_BITS),
      .NUM_FRAMES(NUM_FRAMES),
      .STOP_BITS (STOP_BITS),
      .ADDR_W    (ADDR_W)
   ) dut (
      .K         (K),
      .RST_N     (RST_N),
      .DIN       (DIN),
      .DIN_VALID (DIN_VALID),
      .FRAME_DATA(FRAME_DATA),
      .FRAME_ADDR(FRAME_ADDR),
      .FRAME_WE  (FRAME_WE),
      .LEN_CNT   (LEN_CNT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 K = ~K;

   typedef struct {
      logic [ADDR_W-1:0]     addr;
      logic [FRAME_BITS-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_err = 0;
   int   wr_cnt = 0;
   int   wr0;
   logic prev_we = 1'b0;
   logic busy_seen = 1'b0;
   bit   stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame-write monitor: pops the scoreboard on every strobe
   always @(negedge K) begin
      if (FRAME_WE === 1'b1) begin
         wr_cnt++;
         check("we_width", 32'(prev_we), 32'd0);
         check("we_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("we_addr", 32'(FRAME_ADDR), 32'(e.addr));
            check("we_data", 32'(FRAME_DATA), 32'(e.data));
         end
      end
      prev_we = FRAME_WE;
      if (BUSY === 1'b1) busy_seen = 1'b1;
   end

   task automatic send_bit(input logic b);
      if (stall) begin
         DIN = 1'($urandom);
         DIN_VALID = 1'b0;
         @(posedge K); #1;
      end
      DIN = b;
      DIN_VALID = 1'b1;
      @(posedge K); #1;
      DIN_VALID = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic idle(input int n);
      DIN_VALID = 1'b0;
      repeat (n) begin
         @(posedge K); #1;
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      DIN = 1'b1;
      DIN_VALID = 1'b1;
      @(posedge K); #1;
      RST_N = 1'b1;
      DIN_VALID = 1'b0;
   endtask

   task automatic send_header();
      send_bits(32'hFF, 8);
      send_bits(32'h2, 4);
      send_bits(32'h2A, 24);
      send_bits(32'hF, 4);
   endtask

   task automatic send_frame(input logic [3:0] d, input logic [7:0] a, input bit push,
                             input logic [2:0] stop);
      exp_t x;
      if (push) begin
         x.addr = a;
         x.data = d;
         sb.push_back(x);
      end
      send_bit(1'b0);
      send_bits(32'(d), 4);
      send_bits(32'(stop), 3);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_data"}, 32'(FRAME_DATA), 32'd0);
      check({tag, "_addr"}, 32'(FRAME_ADDR), 32'd0);
      check({tag, "_we"},   32'(FRAME_WE), 32'd0);
      check({tag, "_len"},  32'(LEN_CNT), 32'd0);
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_done"}, 32'(DONE), 32'd0);
      check({tag, "_err"},  32'(ERR), 32'd0);
   endtask

   task automatic run_nominal();
      wr0 = wr_cnt;
      send_bits(32'hFF, 8);
      send_bit(1'b0);
      check("busy_rise", 32'(BUSY), 32'd1);
      send_bits(32'h2, 3);
      send_bits(32'h2A, 24);
      check("len_cnt", 32'(LEN_CNT), 32'h2A);
      send_bits(32'hF, 4);
      send_frame(4'hA, 8'd0, 1'b1, 3'b111);
      check("f0_we", 32'(FRAME_WE), 32'd1);
      check("f0_done", 32'(DONE), 32'd0);
      check("f0_busy", 32'(BUSY), 32'd1);
      send_frame(4'h6, 8'd1, 1'b1, 3'b111);
      check("f1_we", 32'(FRAME_WE), 32'd1);
      check("f1_done", 32'(DONE), 32'd1);
      check("f1_busy", 32'(BUSY), 32'd0);
      check("f1_err", 32'(ERR), 32'd0);
      idle(2);
      check("post_we", 32'(FRAME_WE), 32'd0);
      check("post_done", 32'(DONE), 32'd1);
      check("post_data", 32'(FRAME_DATA), 32'h6);
      check("post_addr", 32'(FRAME_ADDR), 32'd1);
      check("post_len", 32'(LEN_CNT), 32'h2A);
      check("nom_writes", 32'(wr_cnt - wr0), 32'd2);
      check("nom_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_error_hold(input string tag);
      check({tag, "_err"},  32'(ERR), 32'd1);
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_done"}, 32'(DONE), 32'd0);
      send_header();
      send_frame(4'hA, 8'd0, 1'b0, 3'b111);
      send_frame(4'h6, 8'd1, 1'b0, 3'b111);
      idle(2);
      check({tag, "_err_hold"},  32'(ERR), 32'd1);
      check({tag, "_done_hold"}, 32'(DONE), 32'd0);
      check({tag, "_writes"},    32'(wr_cnt - wr0), 32'd0);
      check({tag, "_addr"},      32'(FRAME_ADDR), 32'd0);
   endtask

   initial begin
      RST_N = 1'b0;
      repeat (2) @(posedge K);
      #1;
      check_reset_state("rst");
      RST_N = 1'b1;

      // Nominal load
      run_nominal();

      // Short preamble, then a normal restart
      do_reset();
      wr0 = wr_cnt;
      busy_seen = 1'b0;
      send_bits(32'h7F, 7);
      send_bits(32'h2, 4);
      send_bits(32'h2A, 24);
      send_bits(32'hF, 4);
      send_frame(4'hA, 8'd0, 1'b0, 3'b111);
      send_frame(4'h6, 8'd1, 1'b0, 3'b111);
      idle(1);
      check("short_busy", 32'(busy_seen), 32'd0);
      check("short_writes", 32'(wr_cnt - wr0), 32'd0);
      check("short_len", 32'(LEN_CNT), 32'd0);
      run_nominal();

      // Stalled input
      do_reset();
      stall = 1'b1;
      run_nominal();
      stall = 1'b0;

      // Zero in header end ones
      do_reset();
      wr0 = wr_cnt;
      send_bits(32'hFF, 8);
      send_bits(32'h2, 4);
      send_bits(32'h2A, 24);
      send_bits(32'h6, 3);
      check_error_hold("hend");

      // One as a start bit
      do_reset();
      wr0 = wr_cnt;
      send_header();
      send_bit(1'b1);
      check_error_hold("start");

      // Zero in second stop bit of frame 0
      do_reset();
      wr0 = wr_cnt;
      send_header();
      send_frame(4'hA, 8'd0, 1'b0, 3'b101);
      check_error_hold("stop");

      // Reset in the middle of frame 1
      do_reset();
      send_header();
      send_frame(4'hA, 8'd0, 1'b1, 3'b111);
      send_bit(1'b0);
      send_bits(32'h0, 1);
      send_bits(32'h1, 1);
      wr0 = wr_cnt;
      do_reset();
      check_reset_state("midrst");
      idle(4);
      check("midrst_writes", 32'(wr_cnt - wr0), 32'd0);
      run_nominal();

      // Sync mismatch then recovery
      do_reset();
      send_bits(32'hFF, 8);
      send_bits(32'h3, 4);
      check("mism_err", 32'(ERR), 32'd0);
      check("mism_busy", 32'(BUSY), 32'd0);
      run_nominal();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
